// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Provides the loader state type, instruction width and the NOP word.
package imem_loader_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    typedef enum logic {
        IMEM_LOAD,
        IMEM_RUN
    } imem_state_e;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-wide valid/ready program-load port.
// master: host driving bytes; slave: the loader accepting them.
interface imem_loader_if;

    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Big-endian byte-to-word packer with a 2-bit byte counter.
// Ports: clr (sync clear), byte_en/byte_in/last in; word_valid/word out.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   byte_en,
    input  logic [7:0]             byte_in,
    input  logic                   last,
    output logic                   word_valid,
    output logic [INSTR_WIDTH-1:0] word
);

    logic [1:0]             bc_q, bc_d;
    logic [INSTR_WIDTH-1:0] asm_q, asm_d;

    // asm_q only ever holds already-filled high lanes; the rest stay zero,
    // so an early last yields a zero-padded word for free.
    always_comb begin
        word = asm_q;
        unique case (bc_q)
            2'd0: word[31:24] = byte_in;
            2'd1: word[23:16] = byte_in;
            2'd2: word[15:8]  = byte_in;
            2'd3: word[7:0]   = byte_in;
        endcase
        word_valid = byte_en && ((bc_q == 2'd3) || last);

        bc_d  = bc_q;
        asm_d = asm_q;
        if (clr || word_valid) begin
            bc_d  = 2'd0;
            asm_d = '0;
        end else if (byte_en) begin
            bc_d  = bc_q + 2'd1;
            asm_d = word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_q  <= 2'd0;
            asm_q <= '0;
        end else begin
            bc_q  <= bc_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loaded over a byte stream; holds the core in reset
// until loaded. Ports: clk, rst_n, lif (load port), reload, pc in;
// instr, fetch_fault, core_rst_n, load_done, load_error out.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int PC_WIDTH = imem_loader_pkg::PC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    imem_loader_if.slave           lif,
    input  logic                   reload,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   fetch_fault,
    output logic                   core_rst_n,
    output logic                   load_done,
    output logic                   load_error
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] WC_LAST = (AW+1)'(DEPTH - 1);

    imem_state_e            state_q, state_d;
    logic [AW:0]            wc_q, wc_d;
    logic                   ready_q, ready_d;
    logic                   err_q, err_d;
    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    logic                   accept;
    logic                   clr;
    logic                   mem_we;
    logic                   word_valid;
    logic [INSTR_WIDTH-1:0] word;
    logic                   pc_ok;

    assign accept = lif.load_valid && ready_q;

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .byte_en    (accept),
        .byte_in    (lif.load_data),
        .last       (lif.load_last),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        ready_d = ready_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            IMEM_LOAD: begin
                ready_d = 1'b1;
                if (word_valid) begin
                    mem_we = 1'b1;
                    wc_d   = wc_q + 1'b1;
                    if (lif.load_last) begin
                        state_d = IMEM_RUN;
                        ready_d = 1'b0;
                    end else if (wc_q == WC_LAST) begin
                        // image larger than the array: stop here
                        state_d = IMEM_RUN;
                        ready_d = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            IMEM_RUN: begin
                ready_d = 1'b0;
                if (reload) begin
                    state_d = IMEM_LOAD;
                    ready_d = 1'b1;
                    wc_d    = '0;
                    err_d   = 1'b0;
                    clr     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IMEM_LOAD;
            wc_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[wc_q[AW-1:0]] <= word;
        end
    end

    assign pc_ok = (pc[1:0] == 2'b00) && (pc[PC_WIDTH-1:AW+2] == '0);

    always_comb begin
        instr       = NOP_INSTR;
        fetch_fault = 1'b0;
        if (state_q == IMEM_RUN) begin
            if (pc_ok) begin
                instr = mem_q[pc[AW+1:2]];
            end else begin
                fetch_fault = 1'b1;
            end
        end
    end

    assign lif.load_ready = ready_q;
    assign core_rst_n     = (state_q == IMEM_RUN);
    assign load_done      = (state_q == IMEM_RUN);
    assign load_error     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with a byte-list reference model.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_imem_loader;

    localparam int DEPTH = 4;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        fault;
        logic        ready;
        logic        done;
        logic        crst;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        reload;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fetch_fault;
    logic        core_rst_n;
    logic        load_done;
    logic        load_error;

    imem_loader_if lif ();

    imem_loader #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lif         (lif.slave),
        .reload      (reload),
        .pc          (pc),
        .instr       (instr),
        .fetch_fault (fetch_fault),
        .core_rst_n  (core_rst_n),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_mem [DEPTH];
    bit          m_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (instr !== e.instr || fetch_fault !== e.fault ||
                    lif.load_ready !== e.ready || load_done !== e.done ||
                    core_rst_n !== e.crst || load_error !== e.err) begin
                    errors++;
                    $display("FAIL %s: got instr=%h flt=%b rdy=%b done=%b crst=%b err=%b want instr=%h flt=%b rdy=%b done=%b crst=%b err=%b",
                             e.name, instr, fetch_fault, lif.load_ready,
                             load_done, core_rst_n, load_error, e.instr,
                             e.fault, e.ready, e.done, e.crst, e.err);
                end
            end
        end
    end

    function automatic exp_t mk(string n, logic [31:0] i, logic f,
                                logic r, logic d, logic c, logic e);
        exp_t x;
        x.name = n; x.instr = i; x.fault = f;
        x.ready = r; x.done = d; x.crst = c; x.err = e;
        return x;
    endfunction

    function automatic exp_t run_exp(string n, logic [31:0] p);
        if (p[1:0] != 2'b00 || p >= 32'(4 * DEPTH))
            return mk(n, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, m_err);
        return mk(n, m_mem[p >> 2], 1'b0, 1'b0, 1'b1, 1'b1, m_err);
    endfunction

    // Byte i of the image lands in word i/4, lane 3-(i%4); touched words
    // are rewritten from zero so an early last pads with zeros.
    function automatic void model_apply(logic [7:0] b [$], int nacc);
        for (int w = 0; w < (nacc + 3) / 4; w++) m_mem[w] = 32'h0;
        for (int i = 0; i < nacc; i++)
            m_mem[i / 4][8 * (3 - i % 4) +: 8] = b[i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(exp_t e);
        exp_q.push_back(e);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_last = 1'b0;
        reload = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_err = 1'b0;
        pc = $urandom;
        expect_now(mk("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        expect_now(mk("rst_release", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random gaps
    task automatic load_image(logic [7:0] b [$], bit with_last, int mode);
        int n = b.size();
        int nacc = with_last ? n : 4 * DEPTH;
        int i = 0;
        bit v;
        while (i < nacc) begin
            v = (mode == 0) ? 1'b1 :
                (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            lif.load_valid = v;
            lif.load_data = b[i];
            lif.load_last = with_last && (i == n - 1);
            pc = $urandom;
            expect_now(mk("loading", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            if (v) i++;
        end
        lif.load_valid = 1'b0;
        lif.load_last = 1'b0;
        model_apply(b, nacc);
        m_err = !with_last;
        if (i < n) begin
            lif.load_valid = 1'b1;
            lif.load_data = b[i];
            pc = 32'h0;
            expect_now(run_exp("ovf_refused", 32'h0));
            lif.load_valid = 1'b0;
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        pc = 32'h4;
        expect_now(run_exp("reload_edge", 32'h4));
        reload = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic read_all();
        logic [31:0] p;
        for (int a = 0; a < DEPTH; a++) begin
            pc = 32'(4 * a);
            expect_now(run_exp("fetch", pc));
        end
        pc = 32'h2;
        expect_now(run_exp("misalign", pc));
        pc = 32'(4 * DEPTH);
        expect_now(run_exp("out_of_range", pc));
        for (int k = 0; k < 3; k++) begin
            p = ($urandom_range(0, 1) == 1) ? $urandom
                : 32'($urandom_range(0, 4 * DEPTH + 7));
            pc = p;
            expect_now(run_exp("rand_fetch", p));
        end
    endtask

    initial begin
        logic [7:0] img [$];
        int len;
        rst_n = 1'b0;
        reload = 1'b0;
        pc = 32'h0;
        lif.load_valid = 1'b0;
        lif.load_data = 8'h0;
        lif.load_last = 1'b0;
        tick();
        do_reset();

        img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
        load_image(img, 1'b1, 0);
        pc = 32'h0;
        expect_now(mk("progA_w0", 32'h2008_0005, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        pc = 32'h4;
        expect_now(mk("progA_w1", 32'h2009_0007, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        read_all();

        do_reload();
        img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        load_image(img, 1'b1, 0);
        pc = 32'h4;
        expect_now(mk("partial_w1", 32'h1122_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        read_all();

        do_reload();
        img = {};
        for (int i = 0; i < 17; i++) img.push_back(8'($urandom));
        load_image(img, 1'b0, 0);
        read_all();

        do_reload();
        img = '{8'h00, 8'h00, 8'h00, 8'h0C};
        load_image(img, 1'b1, 1);
        pc = 32'h0;
        expect_now(mk("reload_w0", 32'h0000_000C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        read_all();

        do_reload();
        img = {};
        for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
        load_image(img, 1'b1, 2);
        read_all();

        for (int t = 0; t < 8; t++) begin
            do_reload();
            len = $urandom_range(1, 20);
            img = {};
            for (int i = 0; i < len; i++) img.push_back(8'($urandom));
            load_image(img, len <= 4 * DEPTH, 2);
            read_all();
        end

        do_reload();
        for (int i = 0; i < 2; i++) begin
            lif.load_valid = 1'b1;
            lif.load_data = 8'($urandom);
            expect_now(mk("preabort", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        lif.load_valid = 1'b0;
        do_reset();
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_image(img, 1'b1, 0);
        pc = 32'h0;
        expect_now(mk("after_abort", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        read_all();

        for (int g = 0; g < 10 && exp_q.size() > 0; g++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
